// File: rtl/kv_refill_ctrl.sv
// Refill controller for a WAYS-way set-associative cache: takes a miss plus the LRU victim,
// fetches the line, writes the victim way, then commits the tag and pulses the LRU. Option: KV_REFILL_CRITWORD_EN.
module kv_refill_ctrl #(
    parameter int WAYS       = 4,
    parameter int INDEX_W    = 4,
    parameter int DATA_W     = 32,
    parameter int LINE_BEATS = 4,
    parameter int ADDR_W     = 32,
    localparam int BEAT_W    = $clog2(LINE_BEATS),
    localparam int BYTE_W    = $clog2(DATA_W / 8),
    localparam int OFF_W     = BEAT_W + BYTE_W,
    localparam int TAG_W     = ADDR_W - INDEX_W - OFF_W
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_miss_valid,
    output logic                o_miss_ready,
    input  logic [ADDR_W-1:0]   i_miss_addr,
    input  logic [WAYS-1:0]     i_killmask,
    output logic                o_mem_req_valid,
    input  logic                i_mem_req_ready,
    output logic [ADDR_W-1:0]   o_mem_req_addr,
    input  logic                i_mem_rsp_valid,
    output logic                o_mem_rsp_ready,
    input  logic [DATA_W-1:0]   i_mem_rsp_data,
    output logic                o_wr_en,
    output logic [WAYS-1:0]     o_wr_way,
    output logic [INDEX_W-1:0]  o_wr_index,
    output logic [BEAT_W-1:0]   o_wr_beat,
    output logic [DATA_W-1:0]   o_wr_data,
    output logic                o_tag_we,
    output logic [TAG_W-1:0]    o_tag,
    output logic [WAYS-1:0]     o_hitway,
    output logic [INDEX_W-1:0]  o_index,
    output logic                o_lru_upd
);
    typedef enum logic [1:0] {IDLE, REQ, FILL, COMMIT} state_t;

    localparam logic [WAYS-1:0]   WAY0      = WAYS'(1);
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((64'd1 << OFF_W) - 64'd1);
    localparam logic [ADDR_W-1:0] BYTE_MASK = ADDR_W'((64'd1 << BYTE_W) - 64'd1);

    state_t               state;
    logic [INDEX_W-1:0]   idx_q;
    logic [TAG_W-1:0]     tag_q;
    logic [WAYS-1:0]      victim_q;
    logic [BEAT_W-1:0]    cnt;
    logic [BEAT_W:0]      got;
    logic                 fill_done;

    logic [WAYS-1:0]      victim;
    logic [ADDR_W-1:0]    req_addr;
    logic [BEAT_W-1:0]    start_beat;

    // Lowest set bit of the kill mask; an empty mask falls back to way 0.
    always_comb begin
        victim = i_killmask & (~i_killmask + WAY0);
        if (i_killmask == '0)
            victim = WAY0;
    end

`ifdef KV_REFILL_CRITWORD_EN
    assign req_addr   = i_miss_addr & ~BYTE_MASK;
    assign start_beat = i_miss_addr[OFF_W-1:BYTE_W];
`else
    assign req_addr   = i_miss_addr & ~OFF_MASK;
    assign start_beat = '0;
`endif

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state           <= IDLE;
            idx_q           <= '0;
            tag_q           <= '0;
            victim_q        <= '0;
            cnt             <= '0;
            got             <= '0;
            fill_done       <= 1'b0;
            o_miss_ready    <= 1'b0;
            o_mem_req_valid <= 1'b0;
            o_mem_req_addr  <= '0;
            o_mem_rsp_ready <= 1'b0;
            o_wr_en         <= 1'b0;
            o_wr_way        <= '0;
            o_wr_index      <= '0;
            o_wr_beat       <= '0;
            o_wr_data       <= '0;
            o_tag_we        <= 1'b0;
            o_tag           <= '0;
            o_hitway        <= '0;
            o_index         <= '0;
            o_lru_upd       <= 1'b0;
        end else begin
            o_wr_en   <= 1'b0;
            o_tag_we  <= 1'b0;
            o_lru_upd <= 1'b0;
            o_hitway  <= '0;
            case (state)
                IDLE: begin
                    if (!o_miss_ready) begin
                        o_miss_ready <= 1'b1;
                    end else if (i_miss_valid) begin
                        o_miss_ready    <= 1'b0;
                        idx_q           <= i_miss_addr[OFF_W+INDEX_W-1:OFF_W];
                        tag_q           <= i_miss_addr[ADDR_W-1:OFF_W+INDEX_W];
                        victim_q        <= victim;
                        cnt             <= start_beat;
                        got             <= '0;
                        fill_done       <= 1'b0;
                        o_mem_req_valid <= 1'b1;
                        o_mem_req_addr  <= req_addr;
                        state           <= REQ;
                    end
                end
                REQ: begin
                    if (i_mem_req_ready) begin
                        o_mem_req_valid <= 1'b0;
                        o_mem_rsp_ready <= 1'b1;
                        state           <= FILL;
                    end
                end
                FILL: begin
                    // fill_done holds FILL for the cycle carrying the last write strobe.
                    if (fill_done) begin
                        o_tag_we  <= 1'b1;
                        o_lru_upd <= 1'b1;
                        o_hitway  <= victim_q;
                        o_index   <= idx_q;
                        o_tag     <= tag_q;
                        state     <= COMMIT;
                    end else if (i_mem_rsp_valid && o_mem_rsp_ready) begin
                        o_wr_en    <= 1'b1;
                        o_wr_way   <= victim_q;
                        o_wr_index <= idx_q;
                        o_wr_beat  <= cnt;
                        o_wr_data  <= i_mem_rsp_data;
                        cnt        <= cnt + 1'b1;
                        got        <= got + 1'b1;
                        if (got == (BEAT_W+1)'(LINE_BEATS - 1)) begin
                            fill_done       <= 1'b1;
                            o_mem_rsp_ready <= 1'b0;
                        end
                    end
                end
                COMMIT: begin
                    o_tag        <= '0;
                    o_index      <= '0;
                    o_miss_ready <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kv_refill_ctrl.sv
// Scoreboard bench for kv_refill_ctrl: expected writes/commits are queued as stimulus is
// driven and compared by a negedge monitor as the DUT emits them.
module tb_kv_refill_ctrl;
    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic        i_miss_valid = 1'b0;
    logic        o_miss_ready;
    logic [31:0] i_miss_addr = '0;
    logic [3:0]  i_killmask = '0;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready = 1'b0;
    logic [31:0] o_mem_req_addr;
    logic        i_mem_rsp_valid = 1'b0;
    logic        o_mem_rsp_ready;
    logic [31:0] i_mem_rsp_data = '0;
    logic        o_wr_en;
    logic [3:0]  o_wr_way;
    logic [3:0]  o_wr_index;
    logic [1:0]  o_wr_beat;
    logic [31:0] o_wr_data;
    logic        o_tag_we;
    logic [23:0] o_tag;
    logic [3:0]  o_hitway;
    logic [3:0]  o_index;
    logic        o_lru_upd;

    kv_refill_ctrl dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_miss_valid(i_miss_valid), .o_miss_ready(o_miss_ready),
        .i_miss_addr(i_miss_addr), .i_killmask(i_killmask),
        .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
        .o_mem_req_addr(o_mem_req_addr),
        .i_mem_rsp_valid(i_mem_rsp_valid), .o_mem_rsp_ready(o_mem_rsp_ready),
        .i_mem_rsp_data(i_mem_rsp_data),
        .o_wr_en(o_wr_en), .o_wr_way(o_wr_way), .o_wr_index(o_wr_index),
        .o_wr_beat(o_wr_beat), .o_wr_data(o_wr_data),
        .o_tag_we(o_tag_we), .o_tag(o_tag), .o_hitway(o_hitway),
        .o_index(o_index), .o_lru_upd(o_lru_upd)
    );

    always #5 i_clk = ~i_clk;

`ifdef KV_REFILL_CRITWORD_EN
    localparam bit CW = 1'b1;
`else
    localparam bit CW = 1'b0;
`endif

    typedef struct { logic [3:0] way; logic [3:0] idx; logic [1:0] beat; logic [31:0] data; } wr_t;
    typedef struct { logic [23:0] tag; logic [3:0] way; logic [3:0] idx; } cm_t;

    wr_t  wq[$];
    cm_t  cq[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   wr_seen = 0;
    int   commits = 0;
    bit   prev_wr = 1'b0;
    logic [31:0] cur_addr;
    logic [3:0]  cur_victim;

    wire [127:0] all_out = {o_miss_ready, o_mem_req_valid, o_mem_req_addr, o_mem_rsp_ready,
                            o_wr_en, o_wr_way, o_wr_index, o_wr_beat, o_wr_data, o_tag_we,
                            o_tag, o_hitway, o_index, o_lru_upd};

    function automatic logic [3:0] exp_victim(input logic [3:0] km);
        for (int i = 0; i < 4; i++)
            if (km[i]) return 4'(1 << i);
        return 4'b0001;
    endfunction

    function automatic logic [31:0] exp_req(input logic [31:0] a);
        return CW ? {a[31:2], 2'b00} : {a[31:4], 4'h0};
    endfunction

    always @(negedge i_clk) begin
        if (i_rstn === 1'b1) begin
            if (o_wr_en) begin
                wr_t e;
                wr_seen++;
                n_tests++;
                if (wq.size() == 0) begin
                    n_fail++;
                    $display("FAIL wr_unexpected: got way=%b idx=%0d beat=%0d data=%h, none expected",
                             o_wr_way, o_wr_index, o_wr_beat, o_wr_data);
                end else begin
                    e = wq.pop_front();
                    if ({o_wr_way, o_wr_index, o_wr_beat, o_wr_data} !== {e.way, e.idx, e.beat, e.data}) begin
                        n_fail++;
                        $display("FAIL wr: got way=%b idx=%0d beat=%0d data=%h, exp way=%b idx=%0d beat=%0d data=%h",
                                 o_wr_way, o_wr_index, o_wr_beat, o_wr_data, e.way, e.idx, e.beat, e.data);
                    end
                end
            end
            if (o_tag_we) begin
                cm_t c;
                commits++;
                n_tests++;
                if (cq.size() == 0) begin
                    n_fail++;
                    $display("FAIL commit_unexpected: got tag=%h hitway=%b", o_tag, o_hitway);
                end else begin
                    c = cq.pop_front();
                    if ({o_tag, o_hitway, o_index, o_lru_upd, prev_wr} !== {c.tag, c.way, c.idx, 1'b1, 1'b1}) begin
                        n_fail++;
                        $display("FAIL commit: got tag=%h way=%b idx=%0d lru=%b prev_wr=%b, exp tag=%h way=%b idx=%0d lru=1 prev_wr=1",
                                 o_tag, o_hitway, o_index, o_lru_upd, prev_wr, c.tag, c.way, c.idx);
                    end
                end
            end else if (o_lru_upd || o_hitway != 4'b0) begin
                n_tests++;
                n_fail++;
                $display("FAIL lru_outside_commit: got lru=%b hitway=%b, exp 0/0000", o_lru_upd, o_hitway);
            end
            if (o_mem_rsp_ready) begin
                n_tests++;
                if (o_miss_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_ready: got miss_ready=%b during fill, exp 0", o_miss_ready);
                end
            end
            prev_wr = o_wr_en;
        end else begin
            prev_wr = 1'b0;
        end
    end

    task automatic do_miss(input logic [31:0] a, input logic [3:0] km);
        cm_t c;
        for (int i = 0; i < 50 && o_miss_ready !== 1'b1; i++) begin
            @(posedge i_clk); #1;
        end
        n_tests++;
        if (o_miss_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL miss_ready_timeout: got %b, exp 1", o_miss_ready);
        end
        cur_addr = a;
        cur_victim = exp_victim(km);
        c.tag = a[31:8]; c.way = cur_victim; c.idx = a[7:4];
        cq.push_back(c);
        i_miss_valid = 1'b1; i_miss_addr = a; i_killmask = km;
        @(posedge i_clk); #1;
        i_miss_valid = 1'b0;
        i_killmask = 4'($urandom);
    endtask

    task automatic req_phase(input int stall);
        for (int i = 0; i < 20 && o_mem_req_valid !== 1'b1; i++) begin
            @(posedge i_clk); #1;
        end
        n_tests++;
        if (o_mem_req_valid !== 1'b1 || o_mem_req_addr !== exp_req(cur_addr)) begin
            n_fail++;
            $display("FAIL req: got valid=%b addr=%h, exp 1 addr=%h", o_mem_req_valid, o_mem_req_addr, exp_req(cur_addr));
        end
        for (int i = 0; i < stall; i++) begin
            @(posedge i_clk); #1;
            n_tests++;
            if (o_mem_req_valid !== 1'b1 || o_mem_req_addr !== exp_req(cur_addr)) begin
                n_fail++;
                $display("FAIL req_stall: got valid=%b addr=%h, exp 1 addr=%h", o_mem_req_valid, o_mem_req_addr, exp_req(cur_addr));
            end
        end
        i_mem_req_ready = 1'b1;
        @(posedge i_clk); #1;
        i_mem_req_ready = 1'b0;
        n_tests++;
        if (o_mem_req_valid !== 1'b0 || o_mem_rsp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL req_done: got req_valid=%b rsp_ready=%b, exp 0/1", o_mem_req_valid, o_mem_rsp_ready);
        end
    endtask

    // pat[i] gates the i-th offered cycle; beyond plen every cycle offers a beat.
    task automatic send_beats(input logic [15:0] pat, input int plen, input logic [31:0] base, input int nbeats);
        int k = 0;
        logic [1:0] start = CW ? cur_addr[3:2] : 2'd0;
        for (int i = 0; i < 200 && k < nbeats; i++) begin
            bit v = (i < plen) ? pat[i] : 1'b1;
            bit rdy = o_mem_rsp_ready;
            i_mem_rsp_valid = v;
            i_mem_rsp_data = base + 32'(k);
            @(posedge i_clk); #1;
            if (v && rdy) begin
                wr_t e;
                e.way = cur_victim; e.idx = cur_addr[7:4];
                e.beat = start + 2'(k); e.data = base + 32'(k);
                wq.push_back(e);
                k++;
            end
        end
        i_mem_rsp_valid = 1'b0;
        n_tests++;
        if (k != nbeats) begin
            n_fail++;
            $display("FAIL beats_timeout: got %0d beats accepted, exp %0d", k, nbeats);
        end
    endtask

    task automatic wait_commit();
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge i_clk); #1;
            found = o_tag_we;
        end
        n_tests++;
        if (!found || o_miss_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL commit_wait: got found=%b miss_ready=%b, exp 1/0", found, o_miss_ready);
        end
        @(posedge i_clk); #1;
        n_tests++;
        if (o_miss_ready !== 1'b1 || o_tag_we !== 1'b0) begin
            n_fail++;
            $display("FAIL after_commit: got miss_ready=%b tag_we=%b, exp 1/0", o_miss_ready, o_tag_we);
        end
    endtask

    task automatic refill(input logic [31:0] a, input logic [3:0] km, input logic [31:0] base);
        do_miss(a, km);
        req_phase(0);
        send_beats(16'h0, 0, base, 4);
        wait_commit();
    endtask

    task automatic test_reset();
        i_rstn = 1'b1;
        #1 i_rstn = 1'b0;
        #1;
        n_tests++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, exp 0", all_out);
        end
        repeat (2) @(posedge i_clk);
        #1 i_rstn = 1'b1;
        @(posedge i_clk); #1;
        n_tests++;
        if (o_miss_ready !== 1'b1 || o_mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got miss_ready=%b req_valid=%b, exp 1/0", o_miss_ready, o_mem_req_valid);
        end
    endtask

    task automatic test_basic();
        int w0 = wr_seen;
        refill(32'h0000_1234, 4'b0100, 32'hA000_0000);
        n_tests++;
        if (wr_seen - w0 != 4 || wq.size() != 0 || cq.size() != 0) begin
            n_fail++;
            $display("FAIL basic_count: got %0d writes, %0d/%0d left, exp 4, 0/0", wr_seen - w0, wq.size(), cq.size());
        end
    endtask

    task automatic test_killmask();
        refill(32'h0000_5670, 4'b1010, 32'hB000_0000);
        refill(32'hFFFF_FF0C, 4'b0000, 32'hC000_0000);
        refill(32'h8000_00A4, 4'b1000, 32'hC100_0000);
    endtask

    task automatic test_backpressure();
        int w0 = wr_seen;
        int c0 = commits;
        do_miss(32'h0001_2340, 4'b0001);
        req_phase(5);
        send_beats(16'b1011001, 7, 32'hD000_0000, 4);
        wait_commit();
        n_tests++;
        if (wr_seen - w0 != 4 || commits - c0 != 1) begin
            n_fail++;
            $display("FAIL bp_count: got %0d writes %0d commits, exp 4/1", wr_seen - w0, commits - c0);
        end
    endtask

    task automatic test_reset_midfill();
        int c0 = commits;
        do_miss(32'h0000_0A50, 4'b0010);
        req_phase(0);
        send_beats(16'h0, 0, 32'hE000_0000, 2);
        i_rstn = 1'b0;
        #1;
        n_tests++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL midfill_reset: got %h, exp 0", all_out);
        end
        wq.delete();
        cq.delete();
        repeat (2) @(posedge i_clk);
        #1 i_rstn = 1'b1;
        repeat (4) @(posedge i_clk);
        #1;
        n_tests++;
        if (commits != c0 || o_tag_we !== 1'b0) begin
            n_fail++;
            $display("FAIL midfill_commit: got %0d commits, exp %0d", commits - c0, 0);
        end
        refill(32'h0000_0A50, 4'b0010, 32'hE100_0000);
    endtask

    task automatic test_stray();
        int w0 = wr_seen;
        i_mem_rsp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge i_clk); #1;
            n_tests++;
            if (o_mem_rsp_ready !== 1'b0 || wr_seen != w0) begin
                n_fail++;
                $display("FAIL stray_idle: got rsp_ready=%b writes=%0d, exp 0/0", o_mem_rsp_ready, wr_seen - w0);
            end
        end
        i_mem_rsp_valid = 1'b0;
        do_miss(32'h0000_3310, 4'b0100);
        req_phase(0);
        // A second miss is held throughout the fill and must wait for the commit.
        i_miss_valid = 1'b1; i_miss_addr = 32'h0000_44C8; i_killmask = 4'b1000;
        send_beats(16'b0101, 4, 32'hF000_0000, 4);
        wait_commit();
        cur_addr = 32'h0000_44C8;
        cur_victim = 4'b1000;
        cq.push_back('{tag: 24'h000044, way: 4'b1000, idx: 4'hC});
        @(posedge i_clk); #1;
        i_miss_valid = 1'b0;
        n_tests++;
        if (o_miss_ready !== 1'b0 || o_mem_req_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL held_miss: got miss_ready=%b req_valid=%b, exp 0/1", o_miss_ready, o_mem_req_valid);
        end
        req_phase(1);
        send_beats(16'h0, 0, 32'hF100_0000, 4);
        wait_commit();
    endtask

    task automatic test_critword();
        do_miss(32'h0000_1238, 4'b0001);
        n_tests++;
        if (o_mem_req_addr !== 32'h0000_1238) begin
            n_fail++;
            $display("FAIL cw_addr: got %h, exp 00001238", o_mem_req_addr);
        end
        req_phase(0);
        send_beats(16'h0, 0, 32'h1234_0000, 4);
        wait_commit();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_killmask();
        test_backpressure();
        test_reset_midfill();
        test_stray();
        if (CW) test_critword();
        repeat (3) @(posedge i_clk);
        #1;
        n_tests++;
        if (wq.size() != 0 || cq.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: got %0d writes %0d commits pending, exp 0/0", wq.size(), cq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
